// File: rtl/fsic_upstream_pkg.sv
// Shared encodings for the FSIC upstream AXI-Stream: tid/tuser codes, mailbox
// address-beat field positions and the decoder's state/classification types.
package fsic_upstream_pkg;

    localparam logic [1:0] TUSER_AXIS          = 2'b00;
    localparam logic [1:0] TUSER_AXILITE_WRITE = 2'b01;
    localparam logic [1:0] TUSER_READ_REQ      = 2'b10;
    localparam logic [1:0] TUSER_READ_CPL      = 2'b11;

    localparam logic [1:0] TID_UP_UP = 2'b00;
    localparam logic [1:0] TID_UP_AA = 2'b01;
    localparam logic [1:0] TID_UP_LA = 2'b10;

    // Address beat layout: byte enables in the top nibble, mailbox address below
    localparam int unsigned MB_ADDR_LSB = 0;
    localparam int unsigned MB_BE_LSB   = 28;
    localparam int unsigned MB_BE_WIDTH = 4;

    typedef enum logic {
        S_ADDR = 1'b0,
        S_DATA = 1'b1
    } mb_state_e;

    typedef enum logic [1:0] {
        BEAT_UP   = 2'd0,
        BEAT_WR   = 2'd1,
        BEAT_CPL  = 2'd2,
        BEAT_DROP = 2'd3
    } beat_class_e;

    function automatic beat_class_e classify_beat(
        input logic [1:0] tid,
        input logic [1:0] tuser,
        input logic       tlast
    );
        beat_class_e cls;
        cls = BEAT_DROP;
        if (tid == TID_UP_UP && tuser == TUSER_AXIS)
            cls = BEAT_UP;
        else if (tid == TID_UP_AA && tlast && tuser == TUSER_AXILITE_WRITE)
            cls = BEAT_WR;
        else if (tid == TID_UP_AA && tlast && tuser == TUSER_READ_CPL)
            cls = BEAT_CPL;
        return cls;
    endfunction

endpackage

// File: rtl/fsic_axis_reg_slice.sv
// One-entry valid/ready register slice; a full slice whose consumer is ready
// can drain and reload in the same cycle.
module fsic_axis_reg_slice #(
    parameter int unsigned pWIDTH = 32
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    input  logic              in_valid,
    input  logic [pWIDTH-1:0] in_data,
    output logic              can_load,
    output logic              out_valid,
    output logic [pWIDTH-1:0] out_data,
    input  logic              out_ready
);

    assign can_load = ~out_valid | out_ready;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && can_load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fsic_is_as_upstream_decoder.sv
// Upstream is_as_* decoder: routes user-stream and read-completion beats, pairs
// AA write address/data beats into mailbox writes, drops and counts the rest.
module fsic_is_as_upstream_decoder
    import fsic_upstream_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH    = 32,
    parameter int unsigned pMB_ADDR_WIDTH = 28,
    parameter int unsigned pERR_CNT_WIDTH = 16
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst,
    input  logic [pDATA_WIDTH-1:0]    is_as_tdata,
    input  logic [pDATA_WIDTH/8-1:0]  is_as_tstrb,
    input  logic [pDATA_WIDTH/8-1:0]  is_as_tkeep,
    input  logic                      is_as_tlast,
    input  logic [1:0]                is_as_tid,
    input  logic [1:0]                is_as_tuser,
    input  logic                      is_as_tvalid,
    output logic                      is_as_tready,
    output logic                      mb_wr_valid,
    output logic [pMB_ADDR_WIDTH-1:0] mb_wr_addr,
    output logic [MB_BE_WIDTH-1:0]    mb_wr_be,
    output logic [pDATA_WIDTH-1:0]    mb_wr_data,
    input  logic                      mb_wr_ready,
    output logic                      rd_cpl_valid,
    output logic [pDATA_WIDTH-1:0]    rd_cpl_data,
    input  logic                      rd_cpl_ready,
    output logic                      up_tvalid,
    output logic [pDATA_WIDTH-1:0]    up_tdata,
    output logic [pDATA_WIDTH/8-1:0]  up_tstrb,
    output logic [pDATA_WIDTH/8-1:0]  up_tkeep,
    output logic                      up_tlast,
    input  logic                      up_tready,
    output logic [pERR_CNT_WIDTH-1:0] err_cnt,
    output logic                      wait_data
);

    localparam int unsigned STRB_W = pDATA_WIDTH / 8;
    localparam int unsigned MB_W   = pMB_ADDR_WIDTH + MB_BE_WIDTH + pDATA_WIDTH;
    localparam int unsigned UP_W   = pDATA_WIDTH + 2 * STRB_W + 1;

    mb_state_e                 state, state_nxt;
    beat_class_e               beat_cls;
    logic                      accept;
    logic                      addr_latch, mb_load;
    logic [pMB_ADDR_WIDTH-1:0] addr_q;
    logic [MB_BE_WIDTH-1:0]    be_q;
    logic                      up_can_load, cpl_can_load, mb_can_load;

    always_comb beat_cls = classify_beat(is_as_tid, is_as_tuser, is_as_tlast);

    // An address beat only fills the holding register, so it never waits on the mailbox slice
    always_comb begin
        is_as_tready = 1'b1;
        case (beat_cls)
            BEAT_UP:  is_as_tready = up_can_load;
            BEAT_CPL: is_as_tready = cpl_can_load;
            BEAT_WR:  is_as_tready = (state == S_ADDR) ? 1'b1 : mb_can_load;
            default:  is_as_tready = 1'b1;
        endcase
    end

    assign accept = is_as_tvalid & is_as_tready;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) state <= S_ADDR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ADDR:  if (accept && beat_cls == BEAT_WR) state_nxt = S_DATA;
            S_DATA:  if (accept && beat_cls == BEAT_WR) state_nxt = S_ADDR;
            default: state_nxt = S_ADDR;
        endcase
    end

    always_comb begin
        wait_data  = (state == S_DATA);
        addr_latch = accept && beat_cls == BEAT_WR && state == S_ADDR;
        mb_load    = accept && beat_cls == BEAT_WR && state == S_DATA;
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            addr_q <= '0;
            be_q   <= '0;
        end else if (addr_latch) begin
            addr_q <= is_as_tdata[MB_ADDR_LSB +: pMB_ADDR_WIDTH];
            be_q   <= is_as_tdata[MB_BE_LSB +: MB_BE_WIDTH];
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst)
            err_cnt <= '0;
        else if (accept && beat_cls == BEAT_DROP && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
    end

    fsic_axis_reg_slice #(.pWIDTH(MB_W)) u_mb_slice (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .in_valid  (mb_load),
        .in_data   ({addr_q, be_q, is_as_tdata}),
        .can_load  (mb_can_load),
        .out_valid (mb_wr_valid),
        .out_data  ({mb_wr_addr, mb_wr_be, mb_wr_data}),
        .out_ready (mb_wr_ready)
    );

    fsic_axis_reg_slice #(.pWIDTH(pDATA_WIDTH)) u_cpl_slice (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .in_valid  (accept && beat_cls == BEAT_CPL),
        .in_data   (is_as_tdata),
        .can_load  (cpl_can_load),
        .out_valid (rd_cpl_valid),
        .out_data  (rd_cpl_data),
        .out_ready (rd_cpl_ready)
    );

    fsic_axis_reg_slice #(.pWIDTH(UP_W)) u_up_slice (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .in_valid  (accept && beat_cls == BEAT_UP),
        .in_data   ({is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tlast}),
        .can_load  (up_can_load),
        .out_valid (up_tvalid),
        .out_data  ({up_tdata, up_tstrb, up_tkeep, up_tlast}),
        .out_ready (up_tready)
    );

endmodule

// File: tb/tb_fsic_is_as_upstream_decoder.sv
// Directed bench for the upstream decoder; a queue-based behavioural model is
// compared against the DUT every cycle, plus literal checks on key results.
module tb_fsic_is_as_upstream_decoder;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic [31:0] is_as_tdata = '0;
    logic [3:0]  is_as_tstrb = '0;
    logic [3:0]  is_as_tkeep = '0;
    logic        is_as_tlast = 1'b0;
    logic [1:0]  is_as_tid = '0;
    logic [1:0]  is_as_tuser = '0;
    logic        is_as_tvalid = 1'b0;
    logic        is_as_tready;
    logic        mb_wr_valid;
    logic [27:0] mb_wr_addr;
    logic [3:0]  mb_wr_be;
    logic [31:0] mb_wr_data;
    logic        mb_wr_ready = 1'b1;
    logic        rd_cpl_valid;
    logic [31:0] rd_cpl_data;
    logic        rd_cpl_ready = 1'b1;
    logic        up_tvalid;
    logic [31:0] up_tdata;
    logic [3:0]  up_tstrb;
    logic [3:0]  up_tkeep;
    logic        up_tlast;
    logic        up_tready = 1'b1;
    logic [15:0] err_cnt;
    logic        wait_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    fsic_is_as_upstream_decoder #(
        .pDATA_WIDTH    (32),
        .pMB_ADDR_WIDTH (28),
        .pERR_CNT_WIDTH (16)
    ) dut (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .is_as_tdata  (is_as_tdata),
        .is_as_tstrb  (is_as_tstrb),
        .is_as_tkeep  (is_as_tkeep),
        .is_as_tlast  (is_as_tlast),
        .is_as_tid    (is_as_tid),
        .is_as_tuser  (is_as_tuser),
        .is_as_tvalid (is_as_tvalid),
        .is_as_tready (is_as_tready),
        .mb_wr_valid  (mb_wr_valid),
        .mb_wr_addr   (mb_wr_addr),
        .mb_wr_be     (mb_wr_be),
        .mb_wr_data   (mb_wr_data),
        .mb_wr_ready  (mb_wr_ready),
        .rd_cpl_valid (rd_cpl_valid),
        .rd_cpl_data  (rd_cpl_data),
        .rd_cpl_ready (rd_cpl_ready),
        .up_tvalid    (up_tvalid),
        .up_tdata     (up_tdata),
        .up_tstrb     (up_tstrb),
        .up_tkeep     (up_tkeep),
        .up_tlast     (up_tlast),
        .up_tready    (up_tready),
        .err_cnt      (err_cnt),
        .wait_data    (wait_data)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: undelivered items per channel, pending mailbox address, drop count
    logic [63:0] q_mb[$];
    logic [31:0] q_cpl[$];
    logic [40:0] q_up[$];
    bit          m_pend = 0;
    logic [31:0] m_addr_beat = '0;
    int unsigned m_err = 0;

    logic [63:0] mb_log[$];
    logic [31:0] cpl_log[$];
    logic [40:0] up_log[$];

    function automatic int beat_kind(input logic [1:0] tid, input logic [1:0] tuser, input logic tlast);
        if (tid == 2'd0 && tuser == 2'd0) return 0;
        if (tid == 2'd1 && tlast && tuser == 2'd1) return 1;
        if (tid == 2'd1 && tlast && tuser == 2'd3) return 2;
        return 3;
    endfunction

    always @(negedge axis_clk) begin
        int  k;
        bit  exp_rdy;
        if (axis_rst) begin
            q_mb.delete(); q_cpl.delete(); q_up.delete();
            m_pend = 0; m_err = 0;
            chk("rst_mb_valid", {63'd0, mb_wr_valid}, 64'd0);
            chk("rst_mb_payload", {mb_wr_addr, mb_wr_be, mb_wr_data}, 64'd0);
            chk("rst_cpl", {31'd0, rd_cpl_valid, rd_cpl_data}, 64'd0);
            chk("rst_up", {22'd0, up_tvalid, up_tdata, up_tstrb, up_tkeep, up_tlast}, 64'd0);
            chk("rst_err_wait", {47'd0, err_cnt, wait_data}, 64'd0);
        end else begin
            k = beat_kind(is_as_tid, is_as_tuser, is_as_tlast);
            case (k)
                0: exp_rdy = (q_up.size() == 0) || up_tready;
                1: exp_rdy = !m_pend || (q_mb.size() == 0) || mb_wr_ready;
                2: exp_rdy = (q_cpl.size() == 0) || rd_cpl_ready;
                default: exp_rdy = 1;
            endcase
            chk("tready", {63'd0, is_as_tready}, {63'd0, exp_rdy});
            chk("wait_data", {63'd0, wait_data}, {63'd0, m_pend});
            chk("err_cnt", {48'd0, err_cnt}, 64'(m_err));
            chk("mb_valid", {63'd0, mb_wr_valid}, {63'd0, q_mb.size() != 0});
            if (q_mb.size() != 0) chk("mb_payload", {mb_wr_addr, mb_wr_be, mb_wr_data}, q_mb[0]);
            chk("cpl_valid", {63'd0, rd_cpl_valid}, {63'd0, q_cpl.size() != 0});
            if (q_cpl.size() != 0) chk("cpl_data", {32'd0, rd_cpl_data}, {32'd0, q_cpl[0]});
            chk("up_valid", {63'd0, up_tvalid}, {63'd0, q_up.size() != 0});
            if (q_up.size() != 0) chk("up_beat", {23'd0, up_tdata, up_tstrb, up_tkeep, up_tlast}, {23'd0, q_up[0]});

            if (q_mb.size() != 0 && mb_wr_ready) mb_log.push_back(q_mb.pop_front());
            if (q_cpl.size() != 0 && rd_cpl_ready) cpl_log.push_back(q_cpl.pop_front());
            if (q_up.size() != 0 && up_tready) up_log.push_back(q_up.pop_front());
            if (is_as_tvalid && exp_rdy) begin
                case (k)
                    0: q_up.push_back({is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tlast});
                    1: begin
                        if (!m_pend) begin
                            m_addr_beat = is_as_tdata;
                            m_pend = 1;
                        end else begin
                            q_mb.push_back({m_addr_beat[27:0], m_addr_beat[31:28], is_as_tdata});
                            m_pend = 0;
                        end
                    end
                    2: q_cpl.push_back(is_as_tdata);
                    default: if (m_err < 65535) m_err++;
                endcase
            end
        end
    end

    // Holds the beat until the DUT accepts it; returns one cycle later with tvalid still high
    task automatic send(input logic [1:0] tid, input logic [1:0] tuser, input logic tlast,
                        input logic [31:0] data);
        bit ok;
        is_as_tid = tid; is_as_tuser = tuser; is_as_tlast = tlast; is_as_tdata = data;
        is_as_tstrb = 4'hF; is_as_tkeep = data[3:0];
        is_as_tvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge axis_clk);
            ok = is_as_tready;
            @(posedge axis_clk);
            #1;
        end
        if (!ok) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int unsigned n);
        is_as_tvalid = 1'b0;
        repeat (n) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge axis_clk);
        #1 axis_rst = 1'b0;
        idle(1);

        // Address then data beat -> one mailbox write, valid one cycle after the data beat
        mb_log.delete();
        send(2'd1, 2'd1, 1'b1, 32'hF000_2000);
        send(2'd1, 2'd1, 1'b1, 32'h1234_5678);
        is_as_tvalid = 1'b0;
        @(negedge axis_clk);
        chk("t1_latency_valid", {63'd0, mb_wr_valid}, 64'd1);
        idle(2);
        chk("t1_mb_count", 64'(mb_log.size()), 64'd1);
        if (mb_log.size() == 1) chk("t1_mb_entry", mb_log[0], {28'h0002000, 4'hF, 32'h1234_5678});

        // Completion stalled by rd_cpl_ready=0, second completion held off
        cpl_log.delete();
        rd_cpl_ready = 1'b0;
        send(2'd1, 2'd3, 1'b1, 32'hDEAD_BEEF);
        fork
            send(2'd1, 2'd3, 1'b1, 32'h0BAD_F00D);
            begin
                @(negedge axis_clk);
                chk("t2_stall_tready", {63'd0, is_as_tready}, 64'd0);
                chk("t2_stall_data", {31'd0, rd_cpl_valid, rd_cpl_data}, {31'd0, 1'b1, 32'hDEAD_BEEF});
                @(posedge axis_clk);
                repeat (4) @(posedge axis_clk);
                #1 rd_cpl_ready = 1'b1;
            end
        join
        idle(3);
        chk("t2_cpl_count", 64'(cpl_log.size()), 64'd2);
        if (cpl_log.size() == 2) begin
            chk("t2_cpl_first", {32'd0, cpl_log[0]}, 64'hDEAD_BEEF);
            chk("t2_cpl_second", {32'd0, cpl_log[1]}, 64'h0BAD_F00D);
        end

        // User stream interleaved between address and data beats
        mb_log.delete(); up_log.delete();
        send(2'd1, 2'd1, 1'b1, 32'h3000_0100);
        send(2'd0, 2'd0, 1'b0, 32'h1);
        send(2'd0, 2'd0, 1'b0, 32'h2);
        send(2'd0, 2'd0, 1'b1, 32'h3);
        chk("t3_wait_held", {63'd0, wait_data}, 64'd1);
        send(2'd1, 2'd1, 1'b1, 32'h0000_00A5);
        idle(3);
        chk("t3_up_count", 64'(up_log.size()), 64'd3);
        if (up_log.size() == 3) begin
            chk("t3_up0", {23'd0, up_log[0]}, {23'd0, 32'h1, 4'hF, 4'h1, 1'b0});
            chk("t3_up2", {23'd0, up_log[2]}, {23'd0, 32'h3, 4'hF, 4'h3, 1'b1});
        end
        chk("t3_mb_count", 64'(mb_log.size()), 64'd1);
        if (mb_log.size() == 1) chk("t3_mb_entry", mb_log[0], {28'h0000100, 4'h3, 32'h0000_00A5});

        // Drops while an address is pending: FSM stays in the data phase
        send(2'd1, 2'd1, 1'b1, 32'h1000_0040);
        send(2'd2, 2'd0, 1'b1, 32'h11);
        send(2'd1, 2'd2, 1'b1, 32'h22);
        send(2'd1, 2'd1, 1'b0, 32'h33);
        idle(1);
        chk("t4_err_cnt", {48'd0, err_cnt}, 64'd3);
        chk("t4_wait_kept", {63'd0, wait_data}, 64'd1);
        mb_log.delete();
        send(2'd1, 2'd1, 1'b1, 32'hCAFE_0001);
        idle(3);
        if (mb_log.size() == 1) chk("t4_mb_entry", mb_log[0], {28'h0000040, 4'h1, 32'hCAFE_0001});
        else chk("t4_mb_count", 64'(mb_log.size()), 64'd1);

        // Reset while waiting for data discards the address
        send(2'd1, 2'd1, 1'b1, 32'h2000_0800);
        idle(1);
        chk("t5_wait_before", {63'd0, wait_data}, 64'd1);
        axis_rst = 1'b1;
        idle(1);
        axis_rst = 1'b0;
        idle(1);
        chk("t5_wait_after", {63'd0, wait_data}, 64'd0);
        mb_log.delete();
        send(2'd1, 2'd1, 1'b1, 32'h0000_0004);
        idle(3);
        chk("t5_addr_again", {63'd0, wait_data}, 64'd1);
        chk("t5_no_write", 64'(mb_log.size()), 64'd0);

        // Saturation of the drop counter
        for (int i = 0; i < 70000; i++) send(2'd3, 2'd0, 1'b1, 32'(i));
        idle(2);
        chk("t6_err_sat", {48'd0, err_cnt}, 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsic_is_as_upstream_decoder.md
# fsic_is_as_upstream_decoder

FPGA-side consumer of the FSIC upstream AXI-Stream (`is_as_*`) produced by the FPGA IO-serdes/axis-switch. It classifies each beat by `tid`/`tuser` and:
- pairs Axilite-Adapter (AA) write beats (address, then data) into complete SoC-to-FPGA mailbox write transactions;
- forwards AA read completions on their own channel;
- passes user-project stream beats through.

Illegal or unexpected beats are dropped and counted.

## Interface
Parameters:
- `pDATA_WIDTH`, 32, stream/data width
- `pMB_ADDR_WIDTH`, 28, mailbox address width (`tdata[27:0]` of the address beat)
- `pERR_CNT_WIDTH`, 16, error counter width

Ports:
- `axis_clk` in 1: single clock.
- `axis_rst` in 1: reset, asynchronous, active-high.
- `is_as_tdata` in 32, `is_as_tstrb` in 4, `is_as_tkeep` in 4, `is_as_tlast` in 1, `is_as_tid` in 2, `is_as_tuser` in 2, `is_as_tvalid` in 1: upstream beat.
- `is_as_tready` out 1: beat accepted when `tvalid & tready`.
- `mb_wr_valid` out 1, `mb_wr_addr` out 28, `mb_wr_be` out 4, `mb_wr_data` out 32, `mb_wr_ready` in 1: mailbox write channel.
- `rd_cpl_valid` out 1, `rd_cpl_data` out 32, `rd_cpl_ready` in 1: read completion channel.
- `up_tvalid` out 1, `up_tdata` out 32, `up_tstrb` out 4, `up_tkeep` out 4, `up_tlast` out 1, `up_tready` in 1: user-project stream.
- `err_cnt` out 16: saturating count of dropped beats.
- `wait_data` out 1: decoder holds an address and awaits its data beat.

## Operation
Beat classification:
- `tid`=00 (UP_UP) and `tuser`=00 (AXIS) → user stream slice.
- `tid`=01 (UP_AA), `tuser`=01 (AXILITE_WRITE), `tlast`=1 → mailbox assembler.
- `tid`=01, `tuser`=11 (READ_CPL), `tlast`=1 → completion slice.
- Anything else is dropped: `tid`=10/11, `tuser`=10, AA beat with `tlast`=0, or UP_UP with non-AXIS `tuser`.
  - Dropped beats are always accepted (`tready`=1).
  - `err_cnt` increments by 1 and saturates at all-ones.

Mailbox FSM:
- `S_ADDR`: an accepted AA-write beat latches `addr`=`tdata[27:0]` and `be`=`tdata[31:28]`, then moves to `S_DATA`.
- `S_DATA`: an accepted AA-write beat loads the mailbox output register with the latched `addr`/`be` and `tdata`, then returns to `S_ADDR`.
- `S_DATA` does not block other traffic. UP_UP and READ_CPL beats interleave and are routed normally, and the latched address is kept.
- `wait_data`=1 exactly in `S_DATA`.

`is_as_tready` is combinational from the current `tid`/`tuser`/`tlast`:
- In `S_ADDR`, an AA-write beat always gets `tready`=1.
- Otherwise it equals the target slice's "can load" condition: slice empty, or slice full and its ready is high in the same cycle.

## Timing
- Every output channel is a 1-entry registered slice. Latency from input accept to `*_valid` is 1 cycle.
- Back-to-back throughput is 1 beat/cycle per channel while downstream ready stays high.
- Output data is stable while `valid`=1 and `ready`=0. `valid` drops only after handshake.
- Reset values:
  - All `*_valid`=0.
  - All data, addr and `be` outputs = 0.
  - `err_cnt`=0, `wait_data`=0, FSM in `S_ADDR`.
- Reset mid-transaction discards the latched address and any undelivered slice contents.
- A slice that is full with ready=1 and also receives a new beat performs the handshake and the reload in the same cycle, with no bubble.
- `err_cnt` at max plus a new drop: stays at max.

## Structure
- Shared package `fsic_upstream_pkg`:
  - `TUSER_AXIS`/`AXILITE_WRITE`/`READ_REQ`/`READ_CPL` (2-bit)
  - `TID_UP_UP`/`UP_AA`/`UP_LA` (2-bit)
  - mailbox address-beat field positions
- One sub-module `fsic_axis_reg_slice` (parameter `pWIDTH`; 1-entry valid/ready register with same-cycle drain/load), instantiated three times.
- FSM, classifier and counter stay in the top module.

## Test plan
- AA addr beat `tdata`=`0xF000_2000`, then data beat `0x1234_5678`, with `mb_wr_ready`=1 → one `mb_wr` cycle with `addr`=`0x0002000`, `be`=`0xF`, `data`=`0x12345678`, 1 cycle after the data beat.
- Read completion `tdata`=`0xDEADBEEF` with `rd_cpl_ready`=0 for 5 cycles → `rd_cpl_valid` held with stable data, `is_as_tready`=0 for a second completion, then both delivered in order.
- AA addr `0x3000_0100`, three UP_UP beats `0x1`..`0x3` (last `tlast`=1), then AA data `0xA5` → stream delivered unchanged, then mailbox write `addr`=`0x0000100`, `be`=`0x3`, `data`=`0xA5`.
- Beats with `tid`=10, `tuser`=10, and an AA-write with `tlast`=0 → all accepted and dropped, `err_cnt`=3, FSM state unchanged.
- `axis_rst` pulse while in `S_DATA` → `wait_data`=0. The next AA beat `0x0000_0004` is treated as an address, not data.
- 70000 illegal beats with `pERR_CNT_WIDTH`=16 → `err_cnt`=`0xFFFF`, no wrap.
